// File: rtl/fifo_pkt_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fifo_pkt_reader
//
// Purpose:
//   Pulls fixed-size packets out of a read-latency-1 FIFO and presents them as
//   a valid/ready byte stream. The write side signals "a packet is complete"
//   with package_ready, which lives in another clock domain. Each rising edge
//   of that pulse, after synchronisation, queues one packet. Reads are
//   throttled so that bytes already in flight always fit in a 2-entry output
//   buffer. With tx_ready held high the stream runs at one byte per cycle.
//
// Ports:
//   rd_clk        in   single clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   package_ready in   packet-available pulse (asynchronous, >=1.5 cycles wide)
//   fifo_empty    in   FIFO empty flag
//   fifo_valid    in   FIFO read data valid (one cycle after fifo_rd_en)
//   fifo_dout     in   FIFO read data
//   fifo_rd_en    out  FIFO read request
//   tx_data       out  stream byte
//   tx_valid      out  stream byte valid
//   tx_ready      in   downstream accept
//   tx_sop        out  first byte of packet (qualified by tx_valid)
//   tx_eop        out  last byte of packet (qualified by tx_valid)
//   busy          out  high while not idle
//   pkt_count     out  completed packets, wraps modulo 2^16
//   pend_ovf      out  sticky pending-counter overflow
// -----------------------------------------------------------------------------
module fifo_pkt_reader #(
  parameter int DATA_WIDTH   = 8,
  parameter int PACKAGE_SIZE = 10,
  parameter int PEND_WIDTH   = 4
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  package_ready,
  input  logic                  fifo_empty,
  input  logic                  fifo_valid,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_sop,
  output logic                  tx_eop,
  output logic                  busy,
  output logic [15:0]           pkt_count,
  output logic                  pend_ovf
);

  localparam int CNT_W = $clog2(PACKAGE_SIZE + 1);
  localparam logic [CNT_W-1:0]      PKT_LEN  = CNT_W'(PACKAGE_SIZE);
  localparam logic [CNT_W-1:0]      PKT_LAST = CNT_W'(PACKAGE_SIZE - 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = {PEND_WIDTH{1'b1}};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // sync_q[1:0] is the two-flop synchroniser; sync_q[2] is the previous
  // synchronised value used for rising-edge detection.
  logic [2:0]            sync_q;
  logic [1:0]            state_q,   state_d;
  logic [PEND_WIDTH-1:0] pend_q,    pend_d;
  logic                  ovf_q,     ovf_d;
  logic [CNT_W-1:0]      issued_q,  issued_d;
  logic [CNT_W-1:0]      sent_q,    sent_d;
  logic [15:0]           pkt_cnt_q, pkt_cnt_d;
  logic [1:0]            occ_q,     occ_d;
  logic [DATA_WIDTH-1:0] buf0_q,    buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q,    buf1_d;
  logic                  inflight_q;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic       pkt_event;
  logic       start;
  logic       pop;
  logic       rd_en;
  logic       last_rd;
  logic       head_sop;
  logic       head_eop;
  logic       eop_pop;
  logic [2:0] committed;
  logic       room;

  assign pkt_event = sync_q[1] & ~sync_q[2];
  assign start     = (state_q == ST_IDLE) && (pend_q != '0);
  assign tx_valid  = (occ_q != 2'd0);
  assign pop       = tx_valid && tx_ready;

  // Bytes that will sit in the buffer after this cycle if nothing new is
  // requested: what is stored, plus the read issued last cycle (its data
  // arrives now), minus the byte leaving now. A new read is only allowed if
  // that leaves a free slot, so the 2-entry buffer can never overflow.
  assign committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign room      = (committed < 3'd2);

  assign rd_en   = (state_q == ST_READ) && (issued_q < PKT_LEN) &&
                   !fifo_empty && room;
  assign last_rd = rd_en && (issued_q == PKT_LAST);

  // The buffer head is always the sent_q-th byte of the packet, so the
  // markers come straight from the popped-byte counter and stay stable
  // while the head is stalled.
  assign head_sop = (sent_q == '0);
  assign head_eop = (sent_q == PKT_LAST);
  assign eop_pop  = pop && head_eop;

  // ---------------------------------------------------------------------------
  // Control FSM and byte counters
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    sent_d    = sent_q;
    pkt_cnt_d = pkt_cnt_q;

    if (rd_en) begin
      issued_d = issued_q + 1'b1;
    end
    if (pop) begin
      sent_d = sent_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_READ;
          issued_d = '0;
          sent_d   = '0;
        end
      end
      ST_READ: begin
        if (last_rd) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (eop_pop) begin
          state_d   = ST_IDLE;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pending-packet counter; a start and an event in the same cycle cancel.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    case ({pkt_event, start})
      2'b10: begin
        if (pend_q == PEND_MAX) begin
          ovf_d = 1'b1;
        end else begin
          pend_d = pend_q + 1'b1;
        end
      end
      2'b01: begin
        pend_d = pend_q - 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // 2-entry output buffer, buf0 is the head presented on tx_data.
  // A push into a full buffer without a pop cannot occur because of the
  // read throttle above, so that case simply holds.
  // ---------------------------------------------------------------------------
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case (occ_q)
      2'd0: begin
        if (fifo_valid) begin
          buf0_d = fifo_dout;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        case ({fifo_valid, pop})
          2'b11: begin
            buf0_d = fifo_dout;
          end
          2'b10: begin
            buf1_d = fifo_dout;
            occ_d  = 2'd2;
          end
          2'b01: begin
            occ_d = 2'd0;
          end
          default: begin
          end
        endcase
      end
      2'd2: begin
        if (pop) begin
          buf0_d = buf1_q;
          if (fifo_valid) begin
            buf1_d = fifo_dout;
          end else begin
            occ_d = 2'd1;
          end
        end
      end
      default: begin
        occ_d = 2'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
      issued_q   <= '0;
      sent_q     <= '0;
      pkt_cnt_q  <= '0;
      occ_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], package_ready};
      state_q    <= state_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      pkt_cnt_q  <= pkt_cnt_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      inflight_q <= rd_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign fifo_rd_en = rd_en;
  assign tx_data    = buf0_q;
  assign tx_sop     = tx_valid & head_sop;
  assign tx_eop     = tx_valid & head_eop;
  assign busy       = (state_q != ST_IDLE);
  assign pkt_count  = pkt_cnt_q;
  assign pend_ovf   = ovf_q;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fifo_pkt_reader
//
// Purpose:
//   Directed scenario sequence with randomized payloads, pulse widths and
//   downstream back-pressure. A behavioural FIFO (array + read/write totals)
//   feeds the reader; a monitor checks every accepted byte against the FIFO
//   contents in order, the sop/eop position, hold-while-stalled, and the read
//   throttle (reads issued minus bytes accepted never above 2).
// -----------------------------------------------------------------------------
module tb_fifo_pkt_reader;

  localparam int DW  = 8;
  localparam int PS  = 10;
  localparam int PW  = 4;
  localparam int MEM = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          package_ready;
  logic          fifo_empty;
  logic          fifo_valid;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_sop;
  logic          tx_eop;
  logic          busy;
  logic [15:0]   pkt_count;
  logic          pend_ovf;

  int checks = 0;
  int errors = 0;

  // Behavioural FIFO
  logic [DW-1:0] fmem [0:MEM-1];
  int            pushed_total = 0;
  int            popped_total = 0;
  logic          force_empty;

  // Back-pressure control: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random
  int ready_mode  = 0;
  int ready_phase = 0;

  // Monitor state
  int              exp_idx     = 0;
  int              byte_idx    = 0;
  int              outstanding = 0;
  int              rx_count    = 0;
  logic            stall_prev  = 1'b0;
  logic [DW+1:0]   prev_vec    = '0;
  logic            mon_pop;

  always #5 clk = ~clk;

  assign fifo_empty = force_empty || (pushed_total == popped_total);

  fifo_pkt_reader #(
    .DATA_WIDTH   (DW),
    .PACKAGE_SIZE (PS),
    .PEND_WIDTH   (PW)
  ) dut (
    .rd_clk        (clk),
    .rst_n         (rst_n),
    .package_ready (package_ready),
    .fifo_empty    (fifo_empty),
    .fifo_valid    (fifo_valid),
    .fifo_dout     (fifo_dout),
    .fifo_rd_en    (fifo_rd_en),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_sop        (tx_sop),
    .tx_eop        (tx_eop),
    .busy          (busy),
    .pkt_count     (pkt_count),
    .pend_ovf      (pend_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // FIFO with one-cycle read latency; a reset flushes whatever is left.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_valid   <= 1'b0;
      fifo_dout    <= '0;
      popped_total <= pushed_total;
    end else begin
      fifo_valid <= fifo_rd_en;
      if (fifo_rd_en) begin
        fifo_dout    <= fmem[popped_total % MEM];
        popped_total <= popped_total + 1;
      end
    end
  end

  // Downstream ready driver
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_phase++;
      case (ready_mode)
        1:       tx_ready = ((ready_phase % 4) == 0) || ((ready_phase % 4) == 3);
        2:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // Stream monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs",
          {2'b00, fifo_rd_en, tx_valid, tx_data, tx_sop, tx_eop, busy, pkt_count, pend_ovf},
          32'd0);
      exp_idx     = pushed_total;
      byte_idx    = 0;
      outstanding = 0;
      stall_prev  = 1'b0;
    end else begin
      mon_pop = tx_valid && tx_ready;
      if (fifo_rd_en) begin
        chk("rd_while_empty", fifo_empty, 1'b0);
        chk("rd_throttle", (outstanding - int'(mon_pop)) < 2, 1'b1);
      end
      if (stall_prev) begin
        chk("hold_valid", tx_valid, 1'b1);
        chk("hold_bus", {tx_data, tx_sop, tx_eop}, prev_vec);
      end
      if (mon_pop) begin
        $display("tx byte %0d: data=0x%02h sop=%0b eop=%0b", byte_idx, tx_data, tx_sop, tx_eop);
        chk("tx_data", tx_data, fmem[exp_idx % MEM]);
        chk("tx_sop", tx_sop, byte_idx == 0);
        chk("tx_eop", tx_eop, byte_idx == PS - 1);
        exp_idx++;
        rx_count++;
        byte_idx = (byte_idx == PS - 1) ? 0 : byte_idx + 1;
      end
      outstanding = outstanding + int'(fifo_rd_en) - int'(mon_pop);
      stall_prev  = tx_valid && !tx_ready;
      prev_vec    = {tx_data, tx_sop, tx_eop};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pkt(input bit ramp);
    for (int i = 0; i < PS; i++) begin
      fmem[pushed_total % MEM] = ramp ? DW'(i) : DW'($urandom);
      pushed_total++;
    end
  endtask

  task automatic pulse_ready();
    int w = $urandom_range(2, 4);
    package_ready = 1'b1;
    repeat (w) step();
    package_ready = 1'b0;
    repeat (3) step();
  endtask

  task automatic wait_pkts(input int target, input int budget, input string tag);
    int n = 0;
    while (int'(pkt_count) != target && n < budget) begin
      step();
      n++;
    end
    chk(tag, pkt_count, target);
  endtask

  task automatic wait_rx(input int base, input int target, input int budget, input string tag);
    int n = 0;
    while ((rx_count - base) < target && n < budget) begin
      step();
      n++;
    end
    chk(tag, rx_count - base, target);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_rx;
    int base_pop;
    int k;
    int vcount;

    rst_n         = 1'b0;
    package_ready = 1'b0;
    force_empty   = 1'b0;
    ready_mode    = 0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("idle_outputs",
        {2'b00, fifo_rd_en, tx_valid, tx_data, tx_sop, tx_eop, busy, pkt_count, pend_ovf}, 32'd0);

    // Ramp packet, always ready: latency and back-to-back throughput.
    load_pkt(1'b1);
    base_rx = rx_count;
    package_ready = 1'b1;
    k = 0;
    while (k < 20) begin
      step();
      k++;
      if (k == 2) package_ready = 1'b0;
      if (tx_valid) break;
    end
    // Edges: 2 sync flops, pending visible in IDLE after edge 3, then 3 cycles.
    chk("first_valid_latency", k, 6);
    for (int j = 1; j < PS; j++) begin
      step();
      chk("back_to_back", tx_valid, 1'b1);
    end
    step();
    step();
    chk("pkt_count_s1", pkt_count, 1);
    chk("busy_after_s1", busy, 1'b0);
    chk("rx_bytes_s1", rx_count - base_rx, PS);

    // 1,0,0,1 back-pressure
    ready_mode = 1;
    load_pkt(1'b0);
    base_rx = rx_count;
    pulse_ready();
    wait_pkts(2, 300, "pkt_count_s2");
    chk("rx_bytes_s2", rx_count - base_rx, PS);
    ready_mode = 0;

    // FIFO runs empty after 4 reads for 20 cycles
    load_pkt(1'b0);
    base_rx  = rx_count;
    base_pop = popped_total;
    package_ready = 1'b1;
    k = 0;
    while ((popped_total - base_pop) < 4 && k < 30) begin
      step();
      k++;
      if (k == 2) package_ready = 1'b0;
    end
    package_ready = 1'b0;
    force_empty = 1'b1;
    chk("reads_before_stall", popped_total - base_pop, 4);
    repeat (20) step();
    chk("reads_during_stall", popped_total - base_pop, 4);
    chk("rx_during_stall", rx_count - base_rx, 4);
    chk("busy_during_stall", busy, 1'b1);
    force_empty = 1'b0;
    wait_pkts(3, 100, "pkt_count_s3");
    chk("rx_bytes_s3", rx_count - base_rx, PS);

    // One event then three more while busy, random back-pressure
    ready_mode = 2;
    for (int p = 0; p < 4; p++) load_pkt(1'b0);
    base_rx = rx_count;
    pulse_ready();
    repeat (3) pulse_ready();
    wait_pkts(7, 1000, "pkt_count_s4");
    chk("rx_bytes_s4", rx_count - base_rx, 4 * PS);
    step();
    step();
    chk("busy_after_s4", busy, 1'b0);
    chk("no_ovf_s4", pend_ovf, 1'b0);
    ready_mode = 0;

    // Pending saturation: reads blocked, one packet active, then 15 + 1 events
    force_empty = 1'b1;
    for (int p = 0; p < 16; p++) load_pkt(1'b0);
    base_rx = rx_count;
    pulse_ready();
    repeat (15) pulse_ready();
    repeat (3) step();
    chk("ovf_at_max", pend_ovf, 1'b0);
    pulse_ready();
    repeat (3) step();
    chk("ovf_set", pend_ovf, 1'b1);
    force_empty = 1'b0;
    wait_pkts(7 + 16, 2000, "pkt_count_s5");
    chk("rx_bytes_s5", rx_count - base_rx, 16 * PS);
    chk("ovf_sticky", pend_ovf, 1'b1);

    // Reset in the middle of a packet
    load_pkt(1'b0);
    base_rx = rx_count;
    pulse_ready();
    wait_rx(base_rx, 5, 50, "bytes_before_reset");
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {2'b00, fifo_rd_en, tx_valid, tx_data, tx_sop, tx_eop, busy, pkt_count, pend_ovf}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    vcount = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (tx_valid || busy || fifo_rd_en) vcount++;
    end
    chk("quiet_after_reset", vcount, 0);
    chk("pkt_count_after_reset", pkt_count, 0);
    chk("ovf_after_reset", pend_ovf, 1'b0);
    load_pkt(1'b0);
    base_rx = rx_count;
    pulse_ready();
    wait_pkts(1, 100, "pkt_after_reset");
    chk("rx_bytes_s6", rx_count - base_rx, PS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
